// File: rtl/mealy_xduce_sched_if.sv
// mealy_xduce_sched_if
//   Bundle for the shared serial transducer scheduler.
//   Request side:  req_valid/req_data in, req_ready (one-hot grant) out.
//   Response side: rsp_valid/rsp_id/rsp_data/rsp_state out, rsp_ready in.
//   busy: scheduler is shifting a word or holding a response.
//   master = producers/consumer side, slave = scheduler side.
interface mealy_xduce_sched_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) ();
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [IDW-1:0]         rsp_id;
  logic [WIDTH-1:0]       rsp_data;
  logic [1:0]             rsp_state;
  logic                   busy;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_state, busy
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_state, busy
  );
endinterface

// File: rtl/mealy_xduce_sched.sv
// mealy_xduce_sched
//   Shares one 4-state serial Mealy transducer among N_REQ word requesters.
//   A granted word is shifted LSB-first through the transducer (restarted in
//   S0 per word); the WIDTH output bits come back as one tagged response.
//
//   Ports:
//     clk  - clock, rising edge
//     rst  - asynchronous, active-high reset
//     bus  - mealy_xduce_sched_if.slave: req_valid/req_data/req_ready,
//            rsp_valid/rsp_ready/rsp_id/rsp_data/rsp_state, busy
//
//   Build option: define MXS_FIXED_PRIO_EN for fixed priority arbitration
//   (lowest index wins, pointer held at 0). Default is round-robin.
//
//   state | meaning
//   IDLE  | arbitrating; req_ready is the combinational grant
//   SHIFT | one input bit per cycle through the transducer
//   DONE  | response held on rsp_* until rsp_ready
module mealy_xduce_sched #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic                clk,
  input  logic                rst,
  mealy_xduce_sched_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_id;
  logic [IDW-1:0]   w_grant_idx;
  logic [N_REQ-1:0] w_grant_oh;
  logic             w_grant_any;
  logic             w_accept;
  logic             w_last_bit;
  logic [WIDTH-1:0] r_word;
  logic [WIDTH-1:0] r_result;
  logic [1:0]       r_xs;
  logic [1:0]       w_xs_nxt;
  logic             w_y;
  logic [CW-1:0]    r_cnt;

  // Search starts at r_ptr and wraps. In the fixed-priority build r_ptr
  // never leaves 0, so this degenerates to lowest-index-wins.
  always_comb begin
    int j;
    j           = 0;
    w_grant_oh  = '0;
    w_grant_idx = '0;
    w_grant_any = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(r_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!w_grant_any && bus.req_valid[j]) begin
        w_grant_any = 1'b1;
        w_grant_idx = IDW'(j);
      end
    end
    if (w_grant_any) w_grant_oh[w_grant_idx] = 1'b1;
  end

  assign w_accept   = (r_state == IDLE) && w_grant_any;
  assign w_last_bit = (r_cnt == CW'(WIDTH - 1));

  // Transducer step on the current LSB of the shifting word.
  always_comb begin
    w_xs_nxt = r_xs;
    w_y      = 1'b0;
    case ({r_xs, r_word[0]})
      3'b00_1: begin w_xs_nxt = 2'd0; w_y = 1'b1; end
      3'b00_0: begin w_xs_nxt = 2'd1; w_y = 1'b0; end
      3'b01_1: begin w_xs_nxt = 2'd3; w_y = 1'b0; end
      3'b01_0: begin w_xs_nxt = 2'd2; w_y = 1'b1; end
      3'b10_1: begin w_xs_nxt = 2'd1; w_y = 1'b0; end
      3'b10_0: begin w_xs_nxt = 2'd0; w_y = 1'b1; end
      3'b11_1: begin w_xs_nxt = 2'd2; w_y = 1'b1; end
      3'b11_0: begin w_xs_nxt = 2'd3; w_y = 1'b0; end
      default: begin w_xs_nxt = 2'd0; w_y = 1'b0; end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept)      w_state_nxt = SHIFT;
      SHIFT:   if (w_last_bit)    w_state_nxt = DONE;
      DONE:    if (bus.rsp_ready) w_state_nxt = IDLE;
      default:                    w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // The word is shifted right so bit[count] is always at position 0, and
  // y is shifted in from the top so that after WIDTH steps bit k of the
  // result holds the y produced by input bit k.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr    <= '0;
      r_id     <= '0;
      r_word   <= '0;
      r_result <= '0;
      r_xs     <= 2'd0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_word   <= bus.req_data[int'(w_grant_idx)*WIDTH +: WIDTH];
            r_id     <= w_grant_idx;
            r_result <= '0;
            r_xs     <= 2'd0;
            r_cnt    <= '0;
`ifdef MXS_FIXED_PRIO_EN
            r_ptr    <= '0;
`else
            if (w_grant_idx == IDW'(N_REQ - 1)) r_ptr <= '0;
            else                                r_ptr <= w_grant_idx + 1'b1;
`endif
          end
        end
        SHIFT: begin
          r_word   <= r_word >> 1;
          r_result <= {w_y, r_result[WIDTH-1:1]};
          r_xs     <= w_xs_nxt;
          r_cnt    <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = (r_state == IDLE) ? w_grant_oh : '0;
  assign bus.rsp_valid = (r_state == DONE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.rsp_data  = r_result;
  assign bus.rsp_id    = r_id;
  assign bus.rsp_state = r_xs;

endmodule
